// File: rtl/sram_pkg.sv
// Shared definitions for the parametrised SRAM data-memory controller.
package sram_pkg;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_DONE   = 2'd2;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < v) r = i + 1;
      return r;
   endfunction

   function automatic int beats(input int cpu_dw, input int sram_dw);
      return cpu_dw / sram_dw;
   endfunction

endpackage

// File: rtl/sram_beat_timer.sv
// Beat/wait counter pair: WAIT_CYC+1 cycles per beat, BEATS beats per access.
module sram_beat_timer
   import sram_pkg::*;
#(
   parameter int BEATS    = 2,
   parameter int WAIT_CYC = 1,
   parameter int BW       = (clog2(BEATS) > 0) ? clog2(BEATS) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          run,
   output logic [BW-1:0] beat,
   output logic          last_cycle,
   output logic          last_beat
);

   localparam int WW = clog2(WAIT_CYC + 1);

   logic [WW-1:0] wcnt;

   assign last_cycle = run && (wcnt == WW'(WAIT_CYC));
   assign last_beat  = (beat == BW'(BEATS - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beat <= '0;
         wcnt <= '0;
      end else if (!run) begin
         beat <= '0;
         wcnt <= '0;
      end else if (last_cycle) begin
         wcnt <= '0;
         beat <= last_beat ? '0 : beat + 1'b1;
      end else begin
         wcnt <= wcnt + 1'b1;
      end
   end

endmodule

// File: rtl/sram_ctrl_param.sv
// MEM-stage controller: one CPU_DW load/store as CPU_DW/SRAM_DW SRAM beats.
module sram_ctrl_param
   import sram_pkg::*;
#(
   parameter int          CPU_DW    = 32,
   parameter int          SRAM_DW   = 16,
   parameter int          SRAM_AW   = 18,
   parameter int          WAIT_CYC  = 1,
   parameter int unsigned BASE_ADDR = 1024
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wr_en,
   input  logic               rd_en,
   input  logic [31:0]        addr,
   input  logic [CPU_DW-1:0]  wr_data,
   output logic [CPU_DW-1:0]  rd_data,
   output logic               ready,
   inout  wire  [SRAM_DW-1:0] SRAM_DQ,
   output logic [SRAM_AW-1:0] SRAM_ADDR,
   output logic               SRAM_UB_N,
   output logic               SRAM_LB_N,
   output logic               SRAM_WE_N,
   output logic               SRAM_CE_N,
   output logic               SRAM_OE_N
);

   localparam int BEATS = beats(CPU_DW, SRAM_DW);
   localparam int BW    = (clog2(BEATS) > 0) ? clog2(BEATS) : 1;
   localparam int WSH   = clog2(CPU_DW / 8);
   localparam int BSH   = clog2(BEATS);

   logic [1:0]         state;
   logic               op_wr;
   logic [CPU_DW-1:0]  wdata;
   logic [BW-1:0]      beat;
   logic               last_cycle;
   logic               last_beat;
   logic               req;
   logic               in_acc;
   logic [31:0]        word_idx;
   logic [SRAM_AW-1:0] sram_base;
   logic [SRAM_DW-1:0] dq_out;

   assign req       = rd_en | wr_en;
   assign in_acc    = (state == S_ACCESS);
   assign word_idx  = (addr - 32'(BASE_ADDR)) >> WSH;
   assign sram_base = SRAM_AW'(word_idx << BSH);

   assign ready = ((state == S_IDLE) && !req) || (state == S_DONE);

   sram_beat_timer #(
      .BEATS    (BEATS),
      .WAIT_CYC (WAIT_CYC),
      .BW       (BW)
   ) u_timer (
      .clk        (clk),
      .rst        (rst),
      .run        (in_acc),
      .beat       (beat),
      .last_cycle (last_cycle),
      .last_beat  (last_beat)
   );

   // Address is registered so it stays put between accesses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         op_wr     <= 1'b0;
         wdata     <= '0;
         SRAM_ADDR <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (req) begin
                  state     <= S_ACCESS;
                  op_wr     <= wr_en;
                  wdata     <= wr_data;
                  SRAM_ADDR <= sram_base;
               end
            end
            S_ACCESS: begin
               if (last_cycle) begin
                  if (last_beat) state <= S_DONE;
                  else SRAM_ADDR <= SRAM_ADDR + 1'b1;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         rd_data <= '0;
      else if (in_acc && !op_wr && last_cycle)
         rd_data[beat*SRAM_DW +: SRAM_DW] <= SRAM_DQ;
   end

   assign dq_out  = wdata[beat*SRAM_DW +: SRAM_DW];
   assign SRAM_DQ = (in_acc && op_wr) ? dq_out : {SRAM_DW{1'bz}};

   // Last cycle of a write beat releases WE_N while data is still held.
   assign SRAM_WE_N = !(in_acc && op_wr && !last_cycle);
   assign SRAM_OE_N = !(in_acc && !op_wr);
   assign SRAM_CE_N = !in_acc;
   assign SRAM_UB_N = 1'b0;
   assign SRAM_LB_N = 1'b0;

endmodule

// File: tb/tb_sram_ctrl_param.sv
// Bench for sram_ctrl_param: default and 64-bit/3-wait instances on SRAM models.
module tb_sram_ctrl_param;

   localparam int L0 = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic chk_on = 1'b0;
   int   n_pass = 0;
   int   n_total = 0;

   logic        wr0 = 0, rd0 = 0;
   logic [31:0] addr0 = 0, wd0 = 0;
   logic [31:0] rdd0;
   logic        ready0, ub0, lb0, we0, ce0, oe0;
   logic [17:0] sa0;
   wire  [15:0] dq0;

   logic        wr1 = 0, rd1 = 0;
   logic [31:0] addr1 = 0;
   logic [63:0] wd1 = 0;
   logic [63:0] rdd1;
   logic        ready1, ub1, lb1, we1, ce1, oe1;
   logic [17:0] sa1;
   wire  [15:0] dq1;

   logic [15:0] mem0 [0:63];
   logic [15:0] mem1 [0:63];

   always #5 clk = ~clk;

   sram_ctrl_param d0 (
      .clk(clk), .rst(rst), .wr_en(wr0), .rd_en(rd0), .addr(addr0),
      .wr_data(wd0), .rd_data(rdd0), .ready(ready0), .SRAM_DQ(dq0),
      .SRAM_ADDR(sa0), .SRAM_UB_N(ub0), .SRAM_LB_N(lb0),
      .SRAM_WE_N(we0), .SRAM_CE_N(ce0), .SRAM_OE_N(oe0)
   );

   sram_ctrl_param #(.CPU_DW(64), .WAIT_CYC(3)) d1 (
      .clk(clk), .rst(rst), .wr_en(wr1), .rd_en(rd1), .addr(addr1),
      .wr_data(wd1), .rd_data(rdd1), .ready(ready1), .SRAM_DQ(dq1),
      .SRAM_ADDR(sa1), .SRAM_UB_N(ub1), .SRAM_LB_N(lb1),
      .SRAM_WE_N(we1), .SRAM_CE_N(ce1), .SRAM_OE_N(oe1)
   );

   assign dq0 = (!ce0 && !oe0 && we0) ? mem0[sa0[5:0]] : 16'bz;
   assign dq1 = (!ce1 && !oe1 && we1) ? mem1[sa1[5:0]] : 16'bz;

   always @(negedge clk) begin
      if (!ce0 && !we0) mem0[sa0[5:0]] <= dq0;
      if (!ce1 && !we1) mem1[sa1[5:0]] <= dq1;
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      else
         n_pass++;
   endtask

   // Reference model of instance d0: cycle k of an access, 0 = idle.
   int          k = 0;
   logic        m_wr = 0;
   int          m_base = 0;
   int          m_last = 0;
   int          mb;
   logic [31:0] m_wd = 0;
   logic [31:0] m_rd = 0;
   logic [15:0] smem [0:63];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         k      <= 0;
         m_rd   <= 0;
         m_last <= 0;
      end else if (k == 0) begin
         if (rd0 | wr0) begin
            mb = int'((addr0 - 32'd1024) / 4) * 2;
            k      <= 1;
            m_wr   <= wr0;
            m_base <= mb;
            m_wd   <= wd0;
            if (wr0) begin
               smem[mb % 64]       <= wd0[15:0];
               smem[(mb + 1) % 64] <= wd0[31:16];
            end
         end
      end else if (k == L0) begin
         k      <= L0 + 1;
         m_last <= m_base + 1;
         if (!m_wr)
            m_rd <= {smem[(m_base + 1) % 64], smem[m_base % 64]};
      end else if (k == L0 + 1) begin
         k <= 0;
      end else begin
         k <= k + 1;
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         automatic bit act = (k >= 1 && k <= L0);
         automatic int bt = (k - 1) / 2;
         automatic int wc = (k - 1) % 2;
         chk("ready", ready0, (k == 0 && !(rd0 | wr0)) || k == L0 + 1);
         chk("ce_n", ce0, !act);
         chk("we_n", we0, !(act && m_wr && wc == 0));
         chk("oe_n", oe0, !(act && !m_wr));
         chk("ub_lb", {ub0, lb0, ub1, lb1}, 0);
         chk("sram_addr", sa0, act ? m_base + bt : m_last);
         if (!act) chk("rd_data", rdd0, m_rd);
         if (act && m_wr) chk("dq", dq0, (m_wd >> (16 * bt)) & 32'hFFFF);
      end
   end

   task automatic drive(input bit sel, input bit w, input bit r,
                        input logic [31:0] a, input logic [63:0] d);
      if (!sel) begin
         wr0 = w; rd0 = r; addr0 = a; wd0 = d[31:0];
      end else begin
         wr1 = w; rd1 = r; addr1 = a; wd1 = d;
      end
   endtask

   // One-cycle request; inputs are scrambled afterwards to prove latching.
   task automatic run_op(input bit sel, input bit w, input bit r,
                         input logic [31:0] a, input logic [63:0] d,
                         output int nrdy, output int nwe, output int noe);
      @(posedge clk); #1;
      drive(sel, w, r, a, d);
      nrdy = 0; nwe = 0; noe = 0;
      @(negedge clk);
      while (!(sel ? ready1 : ready0) && nrdy < 100) begin
         nrdy++;
         if (!(sel ? we1 : we0)) nwe++;
         if (!(sel ? oe1 : oe0)) noe++;
         @(posedge clk); #1;
         drive(sel, 0, 0, 32'h0000_2000, 64'hFFFF_FFFF_FFFF_FFFF);
         @(negedge clk);
      end
   endtask

   int nr, nw, no;

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk_on = 1'b1;
      @(negedge clk);
      chk("rst_ready", ready0, 1);
      chk("rst_rd_data", rdd0, 0);
      chk("rst_ctl", {we0, oe0, ce0}, 3'b111);

      run_op(0, 1, 0, 1024, 64'hDEADBEEF, nr, nw, no);
      chk("t1_ready_low", nr, 5);
      chk("t1_we_low", nw, 2);
      chk("t1_mem0", mem0[0], 16'hBEEF);
      chk("t1_mem1", mem0[1], 16'hDEAD);

      run_op(0, 0, 1, 1024, 64'h0F0F_0F0F, nr, nw, no);
      chk("t2_rd_data", rdd0, 32'hDEADBEEF);
      chk("t2_oe_low", no, 4);
      chk("t2_we_low", nw, 0);
      chk("t2_ready_low", nr, 5);

      run_op(0, 1, 0, 1028, 64'h12345678, nr, nw, no);
      chk("t3_mem2", mem0[2], 16'h5678);
      chk("t3_mem3", mem0[3], 16'h1234);
      chk("t3_mem01", {mem0[1], mem0[0]}, 32'hDEADBEEF);
      chk("t3_addr_hold", sa0, 3);

      run_op(0, 1, 1, 1032, 64'hA5A5, nr, nw, no);
      chk("t4_mem4", mem0[4], 16'hA5A5);
      chk("t4_mem5", mem0[5], 16'h0000);
      chk("t4_rd_kept", rdd0, 32'hDEADBEEF);
      chk("t4_oe_low", no, 0);

      @(posedge clk); #1;
      drive(0, 0, 1, 1028, 0);
      @(posedge clk); #1;
      drive(0, 0, 0, 32'h0000_2000, 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("t5_rd_data", rdd0, 0);
      chk("t5_ctl", {we0, oe0, ce0}, 3'b111);
      chk("t5_addr", sa0, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("t5_ready", ready0, 1);
      run_op(0, 0, 1, 1028, 0, nr, nw, no);
      chk("t5_reread", rdd0, 32'h12345678);
      chk("t5_ready_low", nr, 5);

      run_op(1, 1, 0, 1024, 64'h0011_2233_4455_6677, nr, nw, no);
      chk("t6_ready_low", nr, 17);
      chk("t6_we_low", nw, 12);
      chk("t6_mem", {mem1[3], mem1[2], mem1[1], mem1[0]},
          64'h0011_2233_4455_6677);
      chk("t6_rd_data", rdd1, 0);
      chk("t6_addr_hold", sa1, 3);

      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
